// File: rtl/uplink_word_tx.sv
// Serial uplink word transmitter: sends a 5-bit key as a 15-bit {K,~K,K} word of
// UPL1/UPL0 pulses, MSB first, followed by a trailing idle gap.
//
// state | meaning
// IDLE  | waiting for a key; key_ready when not blocked
// PULSE | UPL1 or UPL0 high for the current bit
// SPACE | both lines low for the rest of the bit period
// GAP   | trailing idle gap after bit 14
module uplink_word_tx #(
  parameter int PULSE_W    = 2,
  parameter int BIT_PERIOD = 16,
  parameter int WORD_GAP   = 32
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic [4:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       BLKUPL,
  output logic       UPL0,
  output logic       UPL1,
  output logic       busy,
  output logic       word_done,
  output logic [7:0] sent_cnt
);

  localparam int T_MAX = (BIT_PERIOD > WORD_GAP) ? BIT_PERIOD : WORD_GAP;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] T_PULSE = TW'(PULSE_W - 1);
  localparam logic [TW-1:0] T_SPACE = TW'(BIT_PERIOD - PULSE_W - 1);
  localparam logic [TW-1:0] T_GAP   = TW'(WORD_GAP - 1);

  if (PULSE_W < 1 || PULSE_W >= BIT_PERIOD || WORD_GAP < 1) begin : g_param_check
    $error("uplink_word_tx: illegal PULSE_W / BIT_PERIOD / WORD_GAP");
  end

  typedef enum logic [1:0] {IDLE, PULSE, SPACE, GAP} state_t;

  state_t          state;
  logic [3:0]      bit_idx;
  logic [TW-1:0]   timer;
  logic [14:0]     shreg;

  assign key_ready = (state == IDLE) && !BLKUPL && !rst;

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state     <= IDLE;
      bit_idx   <= 4'd0;
      timer     <= '0;
      shreg     <= '0;
      UPL0      <= 1'b0;
      UPL1      <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
      sent_cnt  <= 8'd0;
    end else begin
      word_done <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid && key_ready) begin
            shreg   <= {key_in, ~key_in, key_in};
            bit_idx <= 4'd0;
            timer   <= T_PULSE;
            UPL1    <= key_in[4];
            UPL0    <= ~key_in[4];
            busy    <= 1'b1;
            state   <= PULSE;
          end
        end
        PULSE: begin
          if (timer == '0) begin
            UPL0  <= 1'b0;
            UPL1  <= 1'b0;
            timer <= T_SPACE;
            state <= SPACE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        SPACE: begin
          if (timer == '0) begin
            if (bit_idx == 4'd14) begin
              timer <= T_GAP;
              state <= GAP;
            end else begin
              // shreg[14] is the bit just sent; the next one sits below it
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {shreg[13:0], 1'b0};
              UPL1    <= shreg[13];
              UPL0    <= ~shreg[13];
              timer   <= T_PULSE;
              state   <= PULSE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        GAP: begin
          if (timer == '0) begin
            bit_idx   <= 4'd0;
            busy      <= 1'b0;
            word_done <= 1'b1;
            sent_cnt  <= sent_cnt + 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
